// File: rtl/stall_flush_controller_if.sv
// stall_flush_controller_if
// Bundles the hazard/control-transfer inputs and the pipeline-register
// controls of stall_flush_controller.
//   master : drives i_* (hazard unit, ID stage, debug unit), observes o_*
//   slave  : the controller itself
// Signals:
//   i_hazard, i_branch_taken, i_jump, i_enable, i_clear_cnt  (to controller)
//   o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble         (pipeline controls)
//   o_stall_cnt, o_flush_cnt [NB_CNT]                        (debug counters)
//   o_timeout                                                (sticky stall timeout)
interface stall_flush_controller_if #(
  parameter int unsigned NB_CNT = 16
);
  logic              i_hazard;
  logic              i_branch_taken;
  logic              i_jump;
  logic              i_enable;
  logic              i_clear_cnt;
  logic              o_pc_we;
  logic              o_ifid_we;
  logic              o_ifid_flush;
  logic              o_idex_bubble;
  logic [NB_CNT-1:0] o_stall_cnt;
  logic [NB_CNT-1:0] o_flush_cnt;
  logic              o_timeout;

  modport master (
    output i_hazard, i_branch_taken, i_jump, i_enable, i_clear_cnt,
    input  o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble,
    input  o_stall_cnt, o_flush_cnt, o_timeout
  );

  modport slave (
    input  i_hazard, i_branch_taken, i_jump, i_enable, i_clear_cnt,
    output o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble,
    output o_stall_cnt, o_flush_cnt, o_timeout
  );
endinterface

// File: rtl/stall_flush_controller.sv
// stall_flush_controller
// Turns the hazard unit's stall request and taken branch/jump events into
// the IF/ID/EX front-end register controls: freezes PC and IF/ID and
// bubbles ID/EX on a stall, flushes IF/ID on a control transfer, counts
// stall and flush cycles, and halts the pipeline with a sticky timeout
// when a stall runs longer than MAX_STALL consecutive cycles.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  asynchronous active-low reset
//   bus      stall_flush_controller_if.slave (events in, controls/counters out)
module stall_flush_controller #(
  parameter int unsigned NB_CNT    = 16,
  parameter int unsigned NB_RUN    = 3,
  parameter int unsigned MAX_STALL = 3
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  stall_flush_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [NB_RUN-1:0] MAX_RUN = NB_RUN'(MAX_STALL);

  state_t            state;
  logic [NB_RUN-1:0] run;
  logic [NB_CNT-1:0] stall_cnt;
  logic [NB_CNT-1:0] flush_cnt;
  logic              timeout;

  logic stall;
  logic xfer;
  logic pc_we;

  // Events and controls are combinational so a stall or flush acts on the
  // same edge as its cause. Gating with i_reset keeps every control low
  // while reset is held, even though the state already reads RUN.
  always_comb begin
    stall = 1'b0;
    xfer  = 1'b0;
    pc_we = 1'b0;
    if (i_reset) begin
      stall = bus.i_enable & bus.i_hazard & (state != HALT);
      // Hazard wins: a taken branch with unready operands waits out the
      // stall and flushes on the first clean cycle. In FLUSH the ID slot
      // holds the injected NOP, so its branch/jump inputs are stale.
      xfer  = bus.i_enable & ~bus.i_hazard
            & (bus.i_branch_taken | bus.i_jump)
            & (state != FLUSH) & (state != HALT);
      pc_we = bus.i_enable & ~stall & (state != HALT);
    end
  end

  assign bus.o_pc_we       = pc_we;
  assign bus.o_ifid_we     = pc_we;
  assign bus.o_idex_bubble = stall;
  assign bus.o_ifid_flush  = xfer;
  assign bus.o_stall_cnt   = stall_cnt;
  assign bus.o_flush_cnt   = flush_cnt;
  assign bus.o_timeout     = timeout;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= RUN;
      run       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      // Event counters: saturating, clear takes priority over increment.
      if (bus.i_clear_cnt) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        if (xfer  && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end

      // State only moves while the debug unit lets the pipeline advance.
      if (bus.i_enable) begin
        unique case (state)
          RUN: begin
            if (stall) begin
              state <= STALL;
              run   <= NB_RUN'(1);
            end else if (xfer) begin
              state <= FLUSH;
            end
          end
          STALL: begin
            if (stall) begin
              if (run == MAX_RUN) begin
                state   <= HALT;
                timeout <= 1'b1;
              end else begin
                run <= run + 1'b1;
              end
            end else begin
              run   <= '0;
              state <= xfer ? FLUSH : RUN;
            end
          end
          FLUSH: begin
            if (stall) begin
              state <= STALL;
              run   <= NB_RUN'(1);
            end else begin
              state <= RUN;
            end
          end
          HALT: begin
            state <= HALT;
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

endmodule
